// File: rtl/conv_sequencer.sv
// Initiator side of the computation_module handshake: latches A/B, pulses send,
// holds the selected run mode until its done, captures C, and reports completion or timeout.
module conv_sequencer #(
  parameter int DW      = 8,
  parameter int TIMEOUT = 64,
  parameter int CW      = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [16*DW-1:0] a_in,
  input  logic [9*DW-1:0]  b_in,
  output logic             busy,
  output logic             res_valid,
  output logic [4*DW-1:0]  res,
  output logic             err,
  output logic             active_send,
  output logic             active_single,
  output logic             active_sa3,
  output logic             active_sa2,
  output logic [16*DW-1:0] a_out,
  output logic [9*DW-1:0]  b_out,
  input  logic             done_send,
  input  logic             done_single,
  input  logic             done_sa3,
  input  logic             done_sa2,
  input  logic [4*DW-1:0]  c_in
);

  localparam logic [1:0] MODE_SINGLE  = 2'd0;
  localparam logic [1:0] MODE_SA3     = 2'd1;
  localparam logic [1:0] MODE_SA2     = 2'd2;
  localparam logic [1:0] MODE_ILLEGAL = 2'd3;

  localparam logic [CW-1:0] TIMER_LIMIT = CW'(TIMEOUT);
  localparam logic [CW-1:0] TIMER_MAX   = {CW{1'b1}};

  typedef enum logic [2:0] {
    IDLE,
    SEND,
    WSEND,
    RUN,
    DONE,
    ABORT
  } state_t;

  state_t        state;
  logic [1:0]    mode_r;
  logic [CW-1:0] timer;
  logic          run_done;
  logic          timer_hit;

  // Only the done belonging to the latched mode can end a run.
  always_comb begin
    run_done = 1'b0;
    case (mode_r)
      MODE_SINGLE: run_done = done_single;
      MODE_SA3:    run_done = done_sa3;
      MODE_SA2:    run_done = done_sa2;
      default:     run_done = 1'b0;
    endcase
  end

  assign timer_hit = (timer == TIMER_LIMIT);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      mode_r        <= MODE_SINGLE;
      timer         <= '0;
      busy          <= 1'b0;
      res_valid     <= 1'b0;
      res           <= '0;
      err           <= 1'b0;
      active_send   <= 1'b0;
      active_single <= 1'b0;
      active_sa3    <= 1'b0;
      active_sa2    <= 1'b0;
      a_out         <= '0;
      b_out         <= '0;
    end else begin
      res_valid   <= 1'b0;
      err         <= 1'b0;
      active_send <= 1'b0;

      case (state)
        IDLE: begin
          if (start) begin
            if (mode == MODE_ILLEGAL) begin
              err <= 1'b1;
            end else begin
              a_out       <= a_in;
              b_out       <= b_in;
              mode_r      <= mode;
              busy        <= 1'b1;
              active_send <= 1'b1;
              state       <= SEND;
            end
          end
        end

        SEND: begin
          timer <= '0;
          state <= WSEND;
        end

        WSEND: begin
          // A done arriving on the limit cycle still wins over the abort.
          if (done_send) begin
            timer         <= '0;
            active_single <= (mode_r == MODE_SINGLE);
            active_sa3    <= (mode_r == MODE_SA3);
            active_sa2    <= (mode_r == MODE_SA2);
            state         <= RUN;
          end else if (timer_hit) begin
            err   <= 1'b1;
            state <= ABORT;
          end else if (timer != TIMER_MAX) begin
            timer <= timer + CW'(1);
          end
        end

        RUN: begin
          if (run_done) begin
            res           <= c_in;
            res_valid     <= 1'b1;
            active_single <= 1'b0;
            active_sa3    <= 1'b0;
            active_sa2    <= 1'b0;
            state         <= DONE;
          end else if (timer_hit) begin
            err           <= 1'b1;
            active_single <= 1'b0;
            active_sa3    <= 1'b0;
            active_sa2    <= 1'b0;
            state         <= ABORT;
          end else if (timer != TIMER_MAX) begin
            timer <= timer + CW'(1);
          end
        end

        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end

        ABORT: begin
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

`ifndef SYNTHESIS
  // At most one request line to the responder may be high at any time.
  a_active_onehot: assert property (@(posedge clk) disable iff (!rst)
    $onehot0({active_send, active_single, active_sa3, active_sa2}));

  a_valid_err_excl: assert property (@(posedge clk) disable iff (!rst)
    !(res_valid && err));
`endif

endmodule
